// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, IF/ID register, one-entry skid buffer, redirect discard.
// Define FETCH_PERF_CNT_EN to build the saturating bubble counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hazard,
    input  logic                 stall_mem,
    input  logic                 flush,
    input  logic [31:0]          branch_target,
    fetch_stage_if.master        imem,
    output logic [31:0]          instruction,
    output logic [31:0]          next_pc,
    output logic                 fetch_busy,
    output logic [31:0]          bubble_count
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_npc;
    logic [31:0] r_skid;
    logic        r_skid_v;
    logic [31:0] r_tgt;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_npc_nxt;
    logic [31:0] w_skid_nxt;
    logic        w_skid_v_nxt;
    logic [31:0] w_tgt_nxt;
    logic [31:0] w_pc_inc;

    assign w_pc_inc        = r_pc + 32'd4;
    assign imem.imem_req   = !rst && (r_state != HELD);
    assign imem.imem_addr  = r_pc;
    assign fetch_busy      = imem.imem_req && !imem.imem_valid;
    assign instruction     = r_instr;
    assign next_pc         = r_npc;

    // Next-state and IF/ID update: stall_mem > flush > hazard > normal.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_npc_nxt    = r_npc;
        w_skid_nxt   = r_skid;
        w_skid_v_nxt = r_skid_v;
        w_tgt_nxt    = r_tgt;
        unique case (r_state)
            FETCH: begin
                if (stall_mem || (!flush && hazard)) begin
                    if (imem.imem_valid) begin
                        w_skid_nxt   = imem.imem_rdata;
                        w_skid_v_nxt = 1'b1;
                        w_state_nxt  = HELD;
                    end
                end else if (flush) begin
                    w_instr_nxt  = NOP;
                    w_npc_nxt    = '0;
                    w_skid_v_nxt = 1'b0;
                    if (imem.imem_valid) begin
                        w_pc_nxt = branch_target;
                    end else begin
                        w_tgt_nxt   = branch_target;
                        w_state_nxt = DISCARD;
                    end
                end else if (imem.imem_valid) begin
                    w_instr_nxt = imem.imem_rdata;
                    w_npc_nxt   = w_pc_inc;
                    w_pc_nxt    = w_pc_inc;
                end else begin
                    w_instr_nxt = NOP;
                    w_npc_nxt   = '0;
                end
            end
            DISCARD: begin
                if (stall_mem) begin
                    w_state_nxt = DISCARD;
                end else if (flush) begin
                    w_instr_nxt  = NOP;
                    w_npc_nxt    = '0;
                    w_skid_v_nxt = 1'b0;
                    if (imem.imem_valid) begin
                        w_pc_nxt    = branch_target;
                        w_state_nxt = FETCH;
                    end else begin
                        w_tgt_nxt = branch_target;
                    end
                end else if (!hazard && imem.imem_valid) begin
                    w_pc_nxt    = r_tgt;
                    w_state_nxt = FETCH;
                end
            end
            HELD: begin
                if (stall_mem) begin
                    w_state_nxt = HELD;
                end else if (flush) begin
                    w_instr_nxt  = NOP;
                    w_npc_nxt    = '0;
                    w_skid_v_nxt = 1'b0;
                    w_pc_nxt     = branch_target;
                    w_state_nxt  = FETCH;
                end else if (!hazard) begin
                    if (r_skid_v) begin
                        w_instr_nxt = r_skid;
                        w_npc_nxt   = w_pc_inc;
                        w_pc_nxt    = w_pc_inc;
                    end
                    w_skid_v_nxt = 1'b0;
                    w_state_nxt  = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= NOP;
            r_npc    <= '0;
            r_skid   <= '0;
            r_skid_v <= 1'b0;
            r_tgt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_npc    <= w_npc_nxt;
            r_skid   <= w_skid_nxt;
            r_skid_v <= w_skid_v_nxt;
            r_tgt    <= w_tgt_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_bubble;
    logic [31:0] r_bubble_cnt;

    // A NOP enters IF/ID on any unstalled flush or an empty unheld fetch.
    assign w_bubble = !stall_mem &&
                      (flush || (r_state == FETCH && !hazard && !imem.imem_valid));

    // Saturating count of NOPs inserted into IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_count = r_bubble_cnt;
`else
    assign bubble_count = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Memory returns rdata equal to the requested address.
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic        hazard;
    logic        stall_mem;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] next_pc;
    logic        fetch_busy;
    logic [31:0] bubble_count;

    int checks;
    int errors;
    int exp_bub;

    fetch_stage_if bus ();

    assign bus.imem_rdata = bus.imem_addr;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .stall_mem     (stall_mem),
        .flush         (flush),
        .branch_target (branch_target),
        .imem          (bus.master),
        .instruction   (instruction),
        .next_pc       (next_pc),
        .fetch_busy    (fetch_busy),
        .bubble_count  (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int bub(input int n);
`ifdef FETCH_PERF_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        exp_bub = 0;
        rst = 1'b1;
        hazard = 1'b0;
        stall_mem = 1'b0;
        flush = 1'b0;
        branch_target = '0;
        bus.imem_valid = 1'b0;
        tick();
        tick();
        chk("rst_instr", instruction, 32'h13);
        chk("rst_npc", next_pc, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_busy", {31'b0, fetch_busy}, 32'h0);
        chk("rst_bub", bubble_count, 32'h0);

        rst = 1'b0;
        #1;
        chk("first_req", {31'b0, bus.imem_req}, 32'h1);
        chk("first_addr", bus.imem_addr, 32'h0);

        bus.imem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("seq_instr", instruction, 32'(i * 4));
            chk("seq_npc", next_pc, 32'(i * 4 + 4));
        end
        tick();
        chk("at_10", bus.imem_addr, 32'h10);

        bus.imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_bub++;
            chk("wait_addr", bus.imem_addr, 32'h10);
            chk("wait_nop", instruction, 32'h13);
            chk("wait_busy", {31'b0, fetch_busy}, 32'h1);
        end
        chk("wait_bub", bubble_count, 32'(bub(exp_bub)));

        bus.imem_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_hz_instr", instruction, 32'h1C);
        chk("pre_hz_addr", bus.imem_addr, 32'h20);

        hazard = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("held_req", {31'b0, bus.imem_req}, 32'h0);
            chk("held_instr", instruction, 32'h1C);
            chk("held_npc", next_pc, 32'h20);
        end
        hazard = 1'b0;
        tick();
        chk("rel_instr", instruction, 32'h20);
        chk("rel_npc", next_pc, 32'h24);
        chk("rel_addr", bus.imem_addr, 32'h24);
        chk("rel_req", {31'b0, bus.imem_req}, 32'h1);

        for (int i = 0; i < 3; i++) tick();
        chk("at_30", bus.imem_addr, 32'h30);

        bus.imem_valid = 1'b0;
        flush = 1'b1;
        branch_target = 32'h100;
        tick();
        exp_bub++;
        flush = 1'b0;
        branch_target = 32'h0;
        chk("fl_nop", instruction, 32'h13);
        chk("fl_addr", bus.imem_addr, 32'h30);
        chk("fl_busy", {31'b0, fetch_busy}, 32'h1);
        tick();
        chk("disc_addr", bus.imem_addr, 32'h30);
        bus.imem_valid = 1'b1;
        tick();
        chk("drop_instr", instruction, 32'h13);
        chk("redir_addr", bus.imem_addr, 32'h100);
        tick();
        chk("tgt_instr", instruction, 32'h100);
        chk("tgt_npc", next_pc, 32'h104);
        chk("fl_bub", bubble_count, 32'(bub(exp_bub)));

        bus.imem_valid = 1'b0;
        stall_mem = 1'b1;
        flush = 1'b1;
        branch_target = 32'h200;
        tick();
        chk("sm_addr", bus.imem_addr, 32'h104);
        chk("sm_instr", instruction, 32'h100);
        chk("sm_npc", next_pc, 32'h104);
        chk("sm_bub", bubble_count, 32'(bub(exp_bub)));
        stall_mem = 1'b0;
        flush = 1'b0;
        branch_target = 32'h0;
        bus.imem_valid = 1'b1;
        tick();
        chk("sm_after", instruction, 32'h104);
        chk("sm_after_addr", bus.imem_addr, 32'h108);

        flush = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        exp_bub++;
        flush = 1'b0;
        branch_target = 32'h0;
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_nop", instruction, 32'h13);
        tick();
        chk("wrap_instr", instruction, 32'hFFFF_FFFC);
        chk("wrap_npc", next_pc, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_bub", bubble_count, 32'(bub(exp_bub)));

        hazard = 1'b1;
        tick();
        chk("h2_req", {31'b0, bus.imem_req}, 32'h0);
        rst = 1'b1;
        #1;
        chk("ar_instr", instruction, 32'h13);
        chk("ar_npc", next_pc, 32'h0);
        chk("ar_req", {31'b0, bus.imem_req}, 32'h0);
        chk("ar_bub", bubble_count, 32'h0);
        tick();
        rst = 1'b0;
        hazard = 1'b0;
        #1;
        chk("ar_addr", bus.imem_addr, 32'h0);
        tick();
        chk("ar_first", instruction, 32'h0);
        chk("ar_first_npc", next_pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset; one clock, asynchronous assert, active-high.
REQ-004 SHALL have port: hazard  input  1  load-use hold; freeze PC and IF/ID.
REQ-005 SHALL have port: stall_mem  input  1  memory-stage stall; freeze PC and IF/ID, ignore flush.
REQ-006 SHALL have port: flush  input  1  redirect request, sampled only when stall_mem=0.
REQ-007 SHALL have port: branch_target  input  32  redirect address, valid with flush.
REQ-008 SHALL have port: imem_req  output  1  instruction-memory request.
REQ-009 SHALL have port: imem_addr  output  32  request address.
REQ-010 SHALL have port: imem_rdata  input  32  returned instruction word.
REQ-011 SHALL have port: imem_valid  input  1  imem_rdata valid for the current imem_addr.
REQ-012 SHALL have port: instruction  output  32  IF/ID instruction to decode.
REQ-013 SHALL have port: next_pc  output  32  IF/ID address of that instruction plus 4.
REQ-014 SHALL have port: fetch_busy  output  1  request outstanding and no word returned this cycle.
REQ-015 SHALL have port: bubble_count  output  32  count of NOPs inserted into IF/ID.

Function
REQ-016 SHALL implement states FETCH, DISCARD, HELD, in a 2-bit state register.
REQ-017 SHALL hold imem_req=1 in FETCH and DISCARD and imem_req=0 in HELD.
REQ-018 SHALL keep imem_addr stable while imem_req=1 and imem_valid=0; imem_addr=pc in FETCH and DISCARD.
REQ-019 SHALL, in FETCH with imem_valid=1 and no hold, load IF/ID {imem_rdata, pc+4} and set pc<=pc+4.
REQ-020 SHALL, in FETCH with imem_valid=0 and no hold, load IF/ID with NOP 32'h0000_0013 and next_pc 0.
REQ-021 SHALL treat hold as (hazard|stall_mem); while held, IF/ID and pc are unchanged.
REQ-022 SHALL, in FETCH with imem_valid=1 during hold, capture imem_rdata into a one-entry skid buffer and go to HELD.
REQ-023 SHALL, in HELD when hold drops, load IF/ID from the skid buffer, set pc<=pc+4, and return to FETCH.
REQ-024 SHALL apply priority stall_mem > flush > hazard > normal.
REQ-025 SHALL, on flush with stall_mem=0, load IF/ID with NOP, set pc<=branch_target, and invalidate the skid buffer.
REQ-026 SHALL, on flush while in FETCH with imem_valid=0, latch branch_target and go to DISCARD.
REQ-027 SHALL, in DISCARD, drop the returned word on imem_valid=1, then set pc to the latched target and go to FETCH.
REQ-028 SHALL, on flush while in DISCARD, overwrite the latched target.
REQ-029 SHALL, on flush while in FETCH with imem_valid=1 or while in HELD, go directly to FETCH at branch_target.
REQ-030 SHALL wrap pc+4 modulo 2^32.
REQ-031 SHALL increment bubble_count on every IF/ID NOP load (REQ-020, REQ-025), saturating at 32'hFFFF_FFFF.

Reset
REQ-032 SHALL, on rst asserted, asynchronously set pc=RESET_PC, state=FETCH, instruction=32'h0000_0013, next_pc=0, skid buffer invalid, and bubble_count=0.
REQ-033 SHALL, with rst asserted, drive imem_req=0 and fetch_busy=0.
REQ-034 SHALL issue the first request at RESET_PC on the first rising clk edge after rst deasserts.
REQ-035 SHALL, on reset during DISCARD or HELD, discard in-flight or buffered data.

Configuration
REQ-036 SHALL support macro FETCH_PERF_CNT_EN: when defined, bubble_count behaves per REQ-031; when undefined, bubble_count is tied to 0 and no counter register exists.

Verification
REQ-037 SHALL check: reset, then imem_valid=1 every cycle with rdata=addr -> instruction sequence 0,4,8, next_pc 4,8,12.
REQ-038 SHALL check: imem_valid low 3 cycles at addr 0x10 -> imem_addr held at 0x10, three NOPs, fetch_busy=1, bubble_count+3.
REQ-039 SHALL check: hazard high 2 cycles while valid arrives at 0x20 -> state HELD, imem_req=0, IF/ID unchanged, then word 0x20 delivered and next request at 0x24.
REQ-040 SHALL check: flush with branch_target=0x100 while waiting at 0x30 -> DISCARD, 0x30 word dropped, next imem_addr=0x100.
REQ-041 SHALL check: flush with stall_mem=1 -> ignored, pc and IF/ID unchanged.
REQ-042 SHALL check: pc=0xFFFF_FFFC fetched -> next_pc=0 and next imem_addr=0.
